// File: rtl/seq_detector_1011.sv
// rtl/seq_detector_1011.sv - Moore detector for serial pattern 1011 with overlap
// Optional saturating detection counter enabled by defining DETECT_COUNT_EN.
module seq_detector_1011 #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in,
   output logic                 detected,
   output logic [CNT_WIDTH-1:0] detect_count
);

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_t;

   state_t state;
   state_t state_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S0;
         detected <= 1'b0;
      end else begin
         state    <= state_next;
         detected <= (state_next == S4);
      end
   end

   // The trailing '1' of a match is reused, so S4 behaves like S1 on the next bit.
   always_comb begin
      state_next = S0;
      case (state)
         S0:      state_next = in ? S1 : S0;
         S1:      state_next = in ? S1 : S2;
         S2:      state_next = in ? S3 : S0;
         S3:      state_next = in ? S4 : S2;
         S4:      state_next = in ? S1 : S2;
         default: state_next = S0;
      endcase
   end

`ifdef DETECT_COUNT_EN
   logic [CNT_WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if ((state_next == S4) && (count != {CNT_WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

   assign detect_count = count;
`else
   assign detect_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_1011.sv
// tb/tb_seq_detector_1011.sv - table-driven scoreboard bench for seq_detector_1011
// Expected counts follow DETECT_COUNT_EN when the bench is built with it defined.
module tb_seq_detector_1011;

   localparam int CW = 2;

   logic          clk;
   logic          rst;
   logic          in;
   logic          detected;
   logic [CW-1:0] detect_count;

   seq_detector_1011 #(.CNT_WIDTH(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in           (in),
      .detected     (detected),
      .detect_count (detect_count)
   );

   typedef struct {
      logic rst;
      logic in;
      logic exp_det;
   } vec_t;

   typedef struct {
      logic          det;
      logic [CW-1:0] cnt;
   } exp_t;

   vec_t  vecs[$];
   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;
   int    model_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 'r' = reset edge with in=0, 'R' = reset edge with in=1, digits = data bits
   task automatic add_seq(input string bits, input string exp);
      vec_t v;
      for (int i = 0; i < bits.len(); i++) begin
         v.rst     = (bits[i] == "r") || (bits[i] == "R");
         v.in      = (bits[i] == "1") || (bits[i] == "R");
         v.exp_det = (exp[i] == "1");
         vecs.push_back(v);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      exp_t e;
      exp_t got;
      rst = v.rst;
      in  = v.in;
      if (v.rst) model_cnt = 0;
`ifdef DETECT_COUNT_EN
      else if (v.exp_det && model_cnt < (1 << CW) - 1) model_cnt++;
`endif
      e.det = v.exp_det;
      e.cnt = model_cnt[CW-1:0];
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      checks++;
      if (detected !== got.det) begin
         errors++;
         $display("FAIL detected vec %0d: got %b expected %b", idx, detected, got.det);
      end
      checks++;
      if (detect_count !== got.cnt) begin
         errors++;
         $display("FAIL detect_count vec %0d: got %0d expected %0d", idx, detect_count, got.cnt);
      end
   endtask

   initial begin
      rst = 1'b1;
      in  = 1'b0;

      add_seq("r",        "0");
      add_seq("1011",     "0001");
      add_seq("r",        "0");
      add_seq("10111011", "00010001");
      add_seq("r",        "0");
      add_seq("1011011",  "0001001");
      add_seq("r",        "0");
      add_seq("11101011", "00000001");
      add_seq("r",        "0");
      add_seq("10011",    "00000");
      add_seq("0000",     "0000");
      add_seq("r",        "0");
      add_seq("101R1011", "00000001");
      add_seq("r",        "0");
      add_seq("10111011101110111011", "00010001000100010001");
      add_seq("0",        "0");

      foreach (vecs[i]) apply(vecs[i], i);

      // Reset mid-match with in=1, then immediately resume a full match
      begin
         vec_t v;
         string s = "1011R1011";
         string x = "000100001";
         for (int i = 0; i < s.len(); i++) begin
            v.rst     = (s[i] == "R");
            v.in      = (s[i] == "1") || (s[i] == "R");
            v.exp_det = (x[i] == "1");
            apply(v, 1000 + i);
         end
      end

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_detector_1011.md
Name: seq_detector_1011

Overview:
- Serial bit-stream pattern detector for the sequence 1-0-1-1; MSB-first in time, with overlapping matches allowed.
- Moore FSM, one bit sampled per clock, with a registered one-cycle detect pulse.
- Sits behind any serial data source (UART/line decoder) as a framing/sync-word flag generator.
- Optionally keeps a saturating count of detections.

Parameters:
- CNT_WIDTH, 8, width of the detect_count output. Only meaningful when DETECT_COUNT_EN is defined; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in  input  1  serial data bit, one bit sampled per rising clk edge.
- detected  output  1  registered pulse, high for the cycle after the final '1' of 1011 is sampled.
- detect_count  output  CNT_WIDTH  number of detections since reset, saturating. Present always; tied to 0 when the feature is off.

Behaviour:
- Single clock domain: one clock, synchronous active-high reset, no other resets.
- Reset state:
  - When rst=1 at a rising edge: state<=S0, detected<=0, detect_count<=0.
  - rst has priority over in on the same edge.
  - Reset asserted mid-sequence discards all partial-match history.
- States (Moore; output decoded from state, held in a flop):
  - S0: no prefix matched.
  - S1: "1" matched.
  - S2: "10" matched.
  - S3: "101" matched.
  - S4: "1011" matched; detected=1.
- Transitions on each rising edge, as (in=0 / in=1):
  - S0: S0 / S1
  - S1: S2 / S1
  - S2: S0 / S3
  - S3: S2 / S4
  - S4: S2 / S1
- Overlap:
  - From S4 the trailing '1' is reused as a new prefix. Stream 1011011 produces two detections.
  - Stream 10111011 also produces two detections.
- Latency: detected rises at the clock edge that samples the final '1' and stays high exactly one cycle, unless the next match completes immediately (impossible for 1011, so the pulse is always a single cycle).
- Encoding: unreachable/illegal state encodings (e.g. 3-bit codes 5–7) return to S0 on the next edge with detected=0.
- No handshake: in is consumed every cycle. The block has no valid qualifier and no back-pressure.
- X-safety: after reset, detected is never X.

Optional Feature:
- Macro: DETECT_COUNT_EN.
- Defined:
  - detect_count increments by 1 on every edge where the next state is S4, so it updates coincident with detected rising.
  - It saturates at 2^CNT_WIDTH-1 and does not wrap.
  - It clears on rst.
- Not defined: detect_count is constant 0, no counter logic is synthesized, and detected behaviour is identical.

Test Plan:
1. Reset, then drive in=1,0,1,1 on consecutive edges -> detected=0 for the first three cycles and 1 for exactly one cycle after the 4th edge. detect_count=1 (with the macro).
2. Drive the continuous stream 1,0,1,1,1,0,1,1 -> detected pulses twice, after bits 4 and 8. detect_count=2.
3. Drive the overlap stream 1,0,1,1,0,1,1 -> pulses after bits 4 and 7. Drive 1,1,1,0,1,0,1,1 -> a single pulse after bit 8.
4. Drive non-matching streams 1,0,0,1,1 and 0,0,0,0 -> detected stays 0 throughout.
5. Drive 1,0,1, then assert rst for one cycle, then drive 1 -> no pulse. Then drive 0,1,1 -> pulse after that sequence completes.
6. With DETECT_COUNT_EN and CNT_WIDTH=2, drive 5 back-to-back matches -> detect_count = 1,2,3,3,3 (saturates). Without the macro -> detect_count=0 throughout.
